vram_arbiter: RTL

Shares the single-port VRAM between the GPU pixel-fetch path and CPU writes, using the `writable` window produced by the video timing generator. CPU writes are absorbed into a small FIFO and drained to VRAM whenever the GPU does not need the port, with guaranteed drain throughput during vertical blank. The block also raises a one-cycle vblank interrupt pulse. It sits between the CPU bus bridge, the GPU fetch unit and the VRAM macro.

---
 rtl/vram_arbiter_pkg.sv | 13 +
 rtl/vram_arbiter_wr_fifo.sv | 49 ++++
 rtl/vram_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default bus widths for the VRAM arbiter and the GPU fetch unit.
package vram_arbiter_pkg;

  // ACTIVE: GPU fetch has priority. BLANK: CPU write drain has priority.
  typedef enum logic {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } mode_e;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 8;

endpackage

// File: rtl/vram_arbiter_wr_fifo.sv
// Small synchronous FIFO holding CPU writes until the VRAM port is free.
// Pointers carry one extra bit so full and empty are distinguishable.
module wr_fifo
  import vram_arbiter_pkg::*;
#(
  parameter int WIDTH = VRAM_ADDR_W + VRAM_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes every pending entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are never visible because empty gates them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between GPU pixel fetch and buffered CPU writes.
// Priority flips with the registered vertical-blank mode derived from writable.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_12_5875,
  input  logic              rst_n,
  input  logic              writable,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              fifo_empty,
  output logic              vblank_irq
);

  mode_e                    mode;
  logic                     fifo_full;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     grant;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  // Ready is held low through reset so no write can slip into a flushing FIFO.
  assign cpu_wr_ready = rst_n && !fifo_full;
  assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
  assign head_addr    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign head_data    = fifo_head[DATA_W-1:0];
  assign gpu_gnt      = grant;
  assign gpu_rdata    = vram_rdata;

  wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk_12_5875),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({cpu_wr_addr, cpu_wr_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Pick at most one VRAM operation per cycle; the mode decides who wins a conflict.
  always_comb begin
    fifo_pop = 1'b0;
    grant    = 1'b0;
    if (rst_n) begin
      if (mode == BLANK) begin
        if (!fifo_empty)  fifo_pop = 1'b1;
        else if (gpu_req) grant    = 1'b1;
      end else begin
        if (gpu_req)          grant    = 1'b1;
        else if (!fifo_empty) fifo_pop = 1'b1;
      end
    end
  end

  // Drive the VRAM port from the winning requester, parking at address zero when idle.
  always_comb begin
    vram_we    = fifo_pop;
    vram_addr  = '0;
    vram_wdata = '0;
    if (fifo_pop) begin
      vram_addr  = head_addr;
      vram_wdata = head_data;
    end else if (grant) begin
      vram_addr = gpu_addr;
    end
  end

  // Mode follows writable one cycle late; the irq marks the first BLANK cycle and rvalid trails the grant.
  always_ff @(posedge clk_12_5875) begin
    if (!rst_n) begin
      mode       <= ACTIVE;
      vblank_irq <= 1'b0;
      gpu_rvalid <= 1'b0;
    end else begin
      mode       <= writable ? BLANK : ACTIVE;
      vblank_irq <= (mode == ACTIVE) && writable;
      gpu_rvalid <= grant;
    end
  end

endmodule
